led_bcd_conv: RTL and testbench
===============================

// Module: led_bcd_conv
// PURPOSE
//  Sequential binary-to-BCD converter (shift-add-3, one bit per clock) between the
//  memory-mapped LED write path and the 7-seg scan/decode stage. Captures the 16-bit
//  LED write word and emits packed BCD digits plus an overflow flag. This replaces the
//  per-cycle /1000, %100 and %10 divider logic on the display path.
// PARAMETERS
//  DATA_W  16  width of the binary input word
//  NDIG    5   BCD digits produced; must satisfy 10^NDIG > 2^DATA_W - 1
// PORTS
//  led_clk   in   1         single system clock; all logic on posedge
//  ledrst    in   1         reset, synchronous, active-high
//  ledwrite  in   1         write strobe from memorio; one word accepted per high cycle
//  ledwdata  in   DATA_W    binary value to convert
//  busy      out  1         conversion in progress
//  done      out  1         one-cycle pulse; bcd_out/ovf updated on the same edge
//  bcd_out   out  4*NDIG    packed digits, [3:0]=units ... [4*NDIG-1:4*NDIG-4]=MS digit
//  ovf       out  1         value > 9999 (exceeds the 4-digit display)
// BEHAVIOUR
//  Reset (ledrst=1 at a posedge): busy=0, done=0, bcd_out=0, ovf=0, pending cleared,
//  FSM->IDLE. Overrides any conversion in flight; the partial result is discarded.
//  FSM states IDLE, SHIFT, DONE:
//   IDLE : ledwrite=1 -> load shift reg=ledwdata, BCD accum=0, bit cnt=0 -> SHIFT.
//   SHIFT: per cycle, for each digit add 3 if >=5, then shift {accum,sreg} left 1;
//          cnt++. After DATA_W SHIFT cycles -> DONE.
//   DONE : bcd_out<=accum, ovf<=(value>9999), done=1 for exactly this cycle.
//          If pending valid: load pending value, clear pending -> SHIFT; else -> IDLE.
//  Latency: accepted at edge N; busy=1 from N+1; done=1 and new bcd_out in the cycle
//  after edge N+DATA_W+1. Default total is 17 cycles.
//  busy=1 in SHIFT and DONE. It stays high across back-to-back DONE->SHIFT.
//  Writes while busy: one-entry pending buffer. Latest write wins; older pending
//  words are overwritten and dropped. A write in the DONE cycle goes to pending
//  and is started next.
//  ledwrite in IDLE is accepted directly and never goes to pending.
//  bcd_out/ovf hold the last completed result between done pulses. They never show
//  partial values.
//  Add-3 correction is applied before each shift, including the first shift.
//  No correction after the final shift.
//  Accumulator is 4*NDIG bits; no carry lost for any DATA_W input.
// CONFIGURATION
//  `LEDBCD_BLANK_EN defined: in DONE, leading zero digits of the result are replaced
//   by 4'hF (blank code, decoded by the downstream segment stage as all segments off).
//   Blanking scans from the MS digit down. Units digit is never blanked, so 0 -> ...FFF0.
//   ovf is computed from the unblanked value.
//  Not defined: plain BCD; zero digits output as 4'h0; no blanking logic.
// TESTING
//  T1 reset, ledwdata=1234, ledwrite 1 cycle -> busy next cycle;
//     done after 17 cycles; bcd_out=20'h01234, ovf=0.
//  T2 ledwdata=65535 -> bcd_out=20'h65535, ovf=1; then 9999 -> 20'h09999, ovf=0.
//  T3 ledwdata=0 -> bcd_out=20'h00000 (BLANK_EN: 20'hFFFF0), ovf=0.
//  T4 write 42; while busy write 7, then 9 -> exactly two done pulses:
//     20'h00042 then 20'h00009; 7 never appears; busy high continuously.
//  T5 write 5000, assert ledrst at cycle 8 of SHIFT -> next cycle busy=0, done=0,
//     bcd_out=0, ovf=0. No done pulse follows. A fresh write of 321 gives 20'h00321.
//  T6 BLANK_EN: 7 -> 20'hFFFF7; 10000 -> 20'h10000, ovf=1; 305 -> 20'hFF305.

Source files
------------

// File: rtl/led_bcd_conv.sv
// -----------------------------------------------------------------------------
// led_bcd_conv
//   Sequential binary-to-BCD converter (shift-add-3, one input bit per clock).
//   Sits between the memory-mapped LED write path and the 7-segment scan/decode
//   stage. It captures a binary word and produces packed BCD digits plus a flag
//   for values that do not fit on the 4-digit display.
//
//   Optional feature: define LEDBCD_BLANK_EN to replace leading zero digits of
//   each result with 4'hF (blank code). The units digit is never blanked.
//
// Parameters
//   DATA_W  width of the binary input word (default 16)
//   NDIG    number of BCD digits produced; 10^NDIG must exceed 2^DATA_W - 1
//
// Ports
//   led_clk   in   system clock, all logic on the rising edge
//   ledrst    in   synchronous active-high reset
//   ledwrite  in   write strobe; one word accepted per high cycle
//   ledwdata  in   [DATA_W-1:0] binary value to convert
//   busy      out  conversion in progress (SHIFT or DONE state)
//   done      out  one-cycle pulse, bcd_out/ovf change on the same edge
//   bcd_out   out  [4*NDIG-1:0] packed digits, [3:0] = units
//   ovf       out  converted value > 9999
// -----------------------------------------------------------------------------
module led_bcd_conv #(
    parameter int DATA_W = 16,
    parameter int NDIG   = 5
) (
    input  logic                led_clk,
    input  logic                ledrst,
    input  logic                ledwrite,
    input  logic [DATA_W-1:0]   ledwdata,
    output logic                busy,
    output logic                done,
    output logic [4*NDIG-1:0]   bcd_out,
    output logic                ovf
);

    localparam int BCD_W  = 4 * NDIG;
    localparam int CNT_W  = $clog2(DATA_W + 1);
    // Digits at and above this bit position mean the value needs a 5th digit.
    localparam int DISP_W = 16;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t             state;
    state_t             nxt_state;
    logic [DATA_W-1:0]  sreg;
    logic [BCD_W-1:0]   accum;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  pend;
    logic               pend_vld;
    logic [BCD_W-1:0]   result;

    // Add-3 correction: any digit >= 5 gets +3 so the following shift carries
    // correctly into the next decimal digit.
    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] a);
        logic [BCD_W-1:0] r;
        r = a;
        for (int i = 0; i < NDIG; i++) begin
            if (a[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = a[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

`ifdef LEDBCD_BLANK_EN
    // Leading-zero blanking, scanning from the MS digit down; digit 0 is never
    // touched so a zero result still shows a single '0'.
    function automatic logic [BCD_W-1:0] blank(input logic [BCD_W-1:0] a);
        logic [BCD_W-1:0] r;
        logic             lead;
        r    = a;
        lead = 1'b1;
        for (int i = NDIG - 1; i > 0; i--) begin
            if (lead && (a[4*i +: 4] == 4'd0))
                r[4*i +: 4] = 4'hF;
            else
                lead = 1'b0;
        end
        return r;
    endfunction

    assign result = blank(accum);
`else
    assign result = accum;
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge led_clk) begin
        if (ledrst)
            state <= IDLE;
        else
            state <= nxt_state;
    end

    always_comb begin
        nxt_state = state;
        case (state)
            IDLE:    if (ledwrite) nxt_state = SHIFT;
            SHIFT:   if (cnt == LAST_BIT) nxt_state = DONE;
            DONE:    nxt_state = (ledwrite || pend_vld) ? SHIFT : IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    // Control and visible outputs: cleared by reset so a conversion in flight
    // is abandoned and no stale result is shown.
    always_ff @(posedge led_clk) begin
        if (ledrst) begin
            done     <= 1'b0;
            bcd_out  <= '0;
            ovf      <= 1'b0;
            pend_vld <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                SHIFT: if (ledwrite) pend_vld <= 1'b1;
                DONE: begin
                    bcd_out  <= result;
                    ovf      <= |accum[BCD_W-1:DISP_W];
                    done     <= 1'b1;
                    // A write in this cycle is started directly, which also
                    // supersedes any older pending word.
                    pend_vld <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Conversion datapath: only meaningful while busy, so no reset needed.
    always_ff @(posedge led_clk) begin
        if ((state == SHIFT) && ledwrite)
            pend <= ledwdata;
        case (state)
            IDLE: begin
                sreg  <= ledwdata;
                accum <= '0;
                cnt   <= '0;
            end
            SHIFT: begin
                {accum, sreg} <= {add3(accum), sreg} << 1;
                cnt           <= cnt + 1'b1;
            end
            DONE: begin
                sreg  <= ledwrite ? ledwdata : pend;
                accum <= '0;
                cnt   <= '0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_led_bcd_conv.sv
module tb_led_bcd_conv;

    logic        led_clk = 1'b0;
    logic        ledrst  = 1'b1;
    logic        ledwrite = 1'b0;
    logic [15:0] ledwdata = '0;
    logic        busy;
    logic        done;
    logic [19:0] bcd_out;
    logic        ovf;

    int checks   = 0;
    int failures = 0;

    // Monitor state updated on every sample point.
    int          done_cnt = 0;
    logic [19:0] hist [0:7];
    logic        hist_ovf [0:7];
    logic        mon_busy = 1'b0;
    int          gaps = 0;

`ifdef LEDBCD_BLANK_EN
    localparam logic [19:0] E1234  = 20'hF1234;
    localparam logic [19:0] E65535 = 20'h65535;
    localparam logic [19:0] E9999  = 20'hF9999;
    localparam logic [19:0] E0     = 20'hFFFF0;
    localparam logic [19:0] E42    = 20'hFFF42;
    localparam logic [19:0] E9     = 20'hFFFF9;
    localparam logic [19:0] E321   = 20'hFF321;
`else
    localparam logic [19:0] E1234  = 20'h01234;
    localparam logic [19:0] E65535 = 20'h65535;
    localparam logic [19:0] E9999  = 20'h09999;
    localparam logic [19:0] E0     = 20'h00000;
    localparam logic [19:0] E42    = 20'h00042;
    localparam logic [19:0] E9     = 20'h00009;
    localparam logic [19:0] E321   = 20'h00321;
`endif

    led_bcd_conv #(.DATA_W(16), .NDIG(5)) dut (
        .led_clk  (led_clk),
        .ledrst   (ledrst),
        .ledwrite (ledwrite),
        .ledwdata (ledwdata),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out),
        .ovf      (ovf)
    );

    always #5 led_clk = ~led_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1ns after the rising edge.
    task automatic tick();
        @(posedge led_clk);
        #1;
        if (done) begin
            if (done_cnt < 8) begin
                hist[done_cnt]     = bcd_out;
                hist_ovf[done_cnt] = ovf;
            end
            done_cnt++;
        end
        if (mon_busy && !busy && !done)
            gaps++;
    endtask

    task automatic write_word(input logic [15:0] v);
        ledwdata = v;
        ledwrite = 1'b1;
        tick();
        ledwrite = 1'b0;
    endtask

    // Wait (bounded) for the next done pulse; returns cycles waited.
    task automatic wait_done(output int n, output logic seen);
        int start;
        start = done_cnt;
        n = 0;
        while ((done_cnt == start) && (n < 40)) begin
            tick();
            n++;
        end
        seen = (done_cnt != start);
    endtask

    task automatic convert(input string tag, input logic [15:0] v,
                           input logic [19:0] exp_bcd, input logic exp_ovf);
        int   n;
        logic seen;
        write_word(v);
        wait_done(n, seen);
        check({tag, "_done_seen"}, {31'b0, seen}, 32'd1);
        check({tag, "_bcd"}, {12'b0, bcd_out}, {12'b0, exp_bcd});
        check({tag, "_ovf"}, {31'b0, ovf}, {31'b0, exp_ovf});
    endtask

    initial begin
        int   n;
        logic seen;
        int   base;

        // Reset state
        tick(); tick(); tick();
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_bcd",  {12'b0, bcd_out}, 32'd0);
        check("rst_ovf",  {31'b0, ovf}, 32'd0);
        ledrst = 1'b0;
        tick();

        // T1: 1234, latency and pulse width
        write_word(16'd1234);
        check("t1_busy_next", {31'b0, busy}, 32'd1);
        wait_done(n, seen);
        check("t1_latency", n, 32'd17);
        check("t1_bcd", {12'b0, bcd_out}, {12'b0, E1234});
        check("t1_ovf", {31'b0, ovf}, 32'd0);
        tick();
        check("t1_done_one_cycle", {31'b0, done}, 32'd0);
        check("t1_bcd_hold", {12'b0, bcd_out}, {12'b0, E1234});
        check("t1_idle", {31'b0, busy}, 32'd0);

        // T2: maximum value and 4-digit boundary
        convert("t2_65535", 16'd65535, E65535, 1'b1);
        convert("t2_9999",  16'd9999,  E9999,  1'b0);
        convert("t2_10000", 16'd10000, 20'h10000, 1'b1);

        // T3: zero
        convert("t3_zero", 16'd0, E0, 1'b0);

        // T4: writes while busy, latest pending wins
        tick();
        base = done_cnt;
        gaps = 0;
        write_word(16'd42);
        mon_busy = 1'b1;
        tick(); tick(); tick();
        write_word(16'd7);
        tick(); tick();
        write_word(16'd9);
        n = 0;
        while ((done_cnt < base + 2) && (n < 60)) begin
            tick();
            n++;
        end
        mon_busy = 1'b0;
        check("t4_two_pulses", done_cnt - base, 32'd2);
        check("t4_first", {12'b0, hist[base]}, {12'b0, E42});
        check("t4_second", {12'b0, hist[base + 1]}, {12'b0, E9});
        check("t4_busy_gaps", gaps, 32'd0);
        for (int i = 0; i < 25; i++) tick();
        check("t4_no_extra", done_cnt - base, 32'd2);

        // T5: reset during SHIFT discards conversion
        write_word(16'd5000);
        for (int i = 0; i < 7; i++) tick();
        base = done_cnt;
        ledrst = 1'b1;
        tick();
        ledrst = 1'b0;
        check("t5_busy", {31'b0, busy}, 32'd0);
        check("t5_done", {31'b0, done}, 32'd0);
        check("t5_bcd",  {12'b0, bcd_out}, 32'd0);
        check("t5_ovf",  {31'b0, ovf}, 32'd0);
        for (int i = 0; i < 25; i++) tick();
        check("t5_no_done", done_cnt - base, 32'd0);
        convert("t5_321", 16'd321, E321, 1'b0);

`ifdef LEDBCD_BLANK_EN
        // T6: blanking
        convert("t6_7",     16'd7,     20'hFFFF7, 1'b0);
        convert("t6_10000", 16'd10000, 20'h10000, 1'b1);
        convert("t6_305",   16'd305,   20'hFF305, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
